// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch controller.
package fetch_pkg;

    // Controller state; explicit values keep the encoding stable across tools.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_e;

    // Source selected onto new_pc.
    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,   // pc_4 from the IF stage
        SEL_TGT  = 2'd1,   // redirect target resolved this cycle
        SEL_PEND = 2'd2,   // redirect target parked during a stall/halt
        SEL_RST  = 2'd3    // reset vector
    } sel_e;

    localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] out
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Count up on inc and stick at the all-ones value instead of wrapping.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: picks the next PC and the PC-hold signal each
// cycle, arbitrating halt > redirect > stall > sequential fetch.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_4,
    input  logic             lu,
    input  logic             md_busy,
    input  logic             br_take,
    input  logic [31:0]      br_target,
    input  logic             jmp_take,
    input  logic [31:0]      jmp_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      new_pc,
    output logic             fetch_stall,
    output logic             if_id_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_pend_v;
    logic [31:0] r_pend_pc;

    sel_e        w_sel;
    logic        w_stall;
    logic        w_flush;
    logic        w_pend_load;
    logic        w_pend_clr;

    logic        w_stall_now;
    logic        w_redirect;
    logic [31:0] w_target;

    assign w_stall_now = lu | md_busy;
    assign w_redirect  = br_take | jmp_take;
    // A jump and a branch in the same cycle cannot both be real; the jump wins.
    assign w_target    = jmp_take ? jmp_target : br_target;

    // State register; reset drops any pending redirect and returns to RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending-redirect slot: the newest redirect seen during a stall wins.
    // NOTE: pend_pc is reset too; it is tiny and a known value eases debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else if (w_pend_load) begin
            r_pend_v  <= 1'b1;
            r_pend_pc <= w_target;
        end else if (w_pend_clr) begin
            r_pend_v  <= 1'b0;
        end
    end

    // Next-state and per-cycle control decode.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel       = SEL_SEQ;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        w_pend_load = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            RUN: begin
                if (halt_req) begin
                    w_state_nxt = HALT;
                    w_stall     = 1'b1;
                    w_flush     = 1'b1;
                end else if (w_redirect && !w_stall_now) begin
                    w_sel   = SEL_TGT;
                    w_flush = 1'b1;
                end else if (w_redirect) begin
                    w_pend_load = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = STALL;
                end else if (w_stall_now) begin
                    w_stall     = 1'b1;
                    w_state_nxt = STALL;
                end
            end
            STALL: begin
                if (halt_req) begin
                    w_state_nxt = HALT;
                    w_stall     = 1'b1;
                    w_flush     = 1'b1;
                end else if (w_stall_now) begin
                    w_stall     = 1'b1;
                    w_pend_load = w_redirect;
                end else begin
                    w_state_nxt = RUN;
                    if (w_redirect) begin
                        // A fresh redirect on the exit cycle supersedes the parked one.
                        w_sel      = SEL_TGT;
                        w_flush    = 1'b1;
                        w_pend_clr = 1'b1;
                    end else if (r_pend_v) begin
                        w_sel      = SEL_PEND;
                        w_flush    = 1'b1;
                        w_pend_clr = 1'b1;
                    end
                end
            end
            HALT: begin
                w_stall = 1'b1;
                if (resume) begin
                    w_state_nxt = RUN;
                    if (r_pend_v) begin
                        w_sel      = SEL_PEND;
                        w_stall    = 1'b0;
                        w_flush    = 1'b1;
                        w_pend_clr = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        // While reset is held the IF stage sees the reset vector and no hold.
        if (rst) begin
            w_sel   = SEL_RST;
            w_stall = 1'b0;
            w_flush = 1'b0;
        end
    end

    // Next-PC mux.
    always_comb begin
        case (w_sel)
            SEL_TGT:  new_pc = w_target;
            SEL_PEND: new_pc = r_pend_pc;
            SEL_RST:  new_pc = RESET_PC;
            default:  new_pc = pc_4;
        endcase
    end

    assign fetch_stall = w_stall;
    assign if_id_flush = w_flush;
    assign halted      = (r_state == HALT);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall),
        .clr (1'b0),
        .out (stall_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected per-cycle outputs.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int          CW     = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_4;
    logic          lu;
    logic          md_busy;
    logic          br_take;
    logic [31:0]   br_target;
    logic          jmp_take;
    logic [31:0]   jmp_target;
    logic          halt_req;
    logic          resume;
    logic [31:0]   new_pc;
    logic          fetch_stall;
    logic          if_id_flush;
    logic          halted;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string         tag;
        logic [31:0]   pc;
        logic          st;
        logic          fl;
        logic          hl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] m_cnt;
    int            n_checks;
    int            n_errors;

    fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_4        (pc_4),
        .lu          (lu),
        .md_busy     (md_busy),
        .br_take     (br_take),
        .br_target   (br_target),
        .jmp_take    (jmp_take),
        .jmp_target  (jmp_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .new_pc      (new_pc),
        .fetch_stall (fetch_stall),
        .if_id_flush (if_id_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Push the expectation for the inputs just driven, update the stall-count
    // model, sample mid-cycle, compare, then move to just after the next edge.
    task automatic cyc(input string tag, input logic [31:0] pc,
                       input logic st, input logic fl, input logic hl);
        exp_t e;
        e.tag = tag;
        e.pc  = pc;
        e.st  = st;
        e.fl  = fl;
        e.hl  = hl;
        e.cnt = m_cnt;
        sb.push_back(e);
        if (st && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
        #4;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".new_pc"}, new_pc, e.pc);
            check({e.tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, e.st});
            check({e.tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, e.fl});
            check({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
            check({e.tag, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.cnt});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_cnt      = '0;
        rst        = 1'b1;
        pc_4       = 32'h4;
        lu         = 1'b1;
        md_busy    = 1'b0;
        br_take    = 1'b0;
        br_target  = '0;
        jmp_take   = 1'b0;
        jmp_target = '0;
        halt_req   = 1'b1;
        resume     = 1'b0;
        @(posedge clk);
        #1;

        // Reset overrides hazards: reset vector, no hold, no flush.
        cyc("rst", RST_PC, 1'b0, 1'b0, 1'b0);
        rst      = 1'b0;
        lu       = 1'b0;
        halt_req = 1'b0;

        // Sequential fetch.
        pc_4 = 32'h100;
        cyc("seq", 32'h100, 1'b0, 1'b0, 1'b0);

        // Zero-latency redirects; jump beats branch.
        br_take = 1'b1; br_target = 32'h40;
        cyc("br", 32'h40, 1'b0, 1'b1, 1'b0);
        jmp_take = 1'b1; jmp_target = 32'h80;
        cyc("jmp_over_br", 32'h80, 1'b0, 1'b1, 1'b0);
        jmp_take = 1'b0;

        // Redirect under load-use is parked, then md_busy holds two more cycles.
        pc_4 = 32'h104; lu = 1'b1; br_target = 32'h200;
        cyc("lu_br", 32'h104, 1'b1, 1'b0, 1'b0);
        lu = 1'b0; br_take = 1'b0; md_busy = 1'b1;
        cyc("md1", 32'h104, 1'b1, 1'b0, 1'b0);
        cyc("md2", 32'h104, 1'b1, 1'b0, 1'b0);
        md_busy = 1'b0;
        cyc("pend_apply", 32'h200, 1'b0, 1'b1, 1'b0);
        pc_4 = 32'h204;
        cyc("pend_cleared", 32'h204, 1'b0, 1'b0, 1'b0);

        // Newest parked redirect wins.
        lu = 1'b1; br_take = 1'b1; br_target = 32'h300;
        cyc("park_old", 32'h204, 1'b1, 1'b0, 1'b0);
        br_take = 1'b0; jmp_take = 1'b1; jmp_target = 32'h380;
        cyc("park_new", 32'h204, 1'b1, 1'b0, 1'b0);
        lu = 1'b0; jmp_take = 1'b0;
        cyc("park_apply", 32'h380, 1'b0, 1'b1, 1'b0);

        // Halt: inputs toggled while halted have no effect.
        pc_4 = 32'h208; halt_req = 1'b1;
        cyc("halt_req", 32'h208, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pc_4       = 32'h400 + 32'(i * 4);
            lu         = 1'($urandom_range(0, 1));
            md_busy    = 1'($urandom_range(0, 1));
            br_take    = 1'b1;
            br_target  = 32'hDEAD_0000 + 32'(i);
            jmp_take   = 1'($urandom_range(0, 1));
            jmp_target = 32'hBEEF_0000 + 32'(i);
            halt_req   = 1'($urandom_range(0, 1));
            cyc("halted", pc_4, 1'b1, 1'b0, 1'b1);
        end
        lu = 1'b0; md_busy = 1'b0; br_take = 1'b0; jmp_take = 1'b0; halt_req = 1'b0;
        pc_4 = 32'h500; resume = 1'b1;
        cyc("resume_hold", 32'h500, 1'b1, 1'b0, 1'b1);
        resume = 1'b0;
        cyc("run_after_halt", 32'h500, 1'b0, 1'b0, 1'b0);

        // Pending redirect survives a halt and is applied on resume.
        lu = 1'b1; br_take = 1'b1; br_target = 32'h600;
        cyc("park_pre_halt", 32'h500, 1'b1, 1'b0, 1'b0);
        br_take = 1'b0; halt_req = 1'b1;
        cyc("halt_in_stall", 32'h500, 1'b1, 1'b1, 1'b0);
        lu = 1'b0; halt_req = 1'b0;
        cyc("halt_pend", 32'h500, 1'b1, 1'b0, 1'b1);
        resume = 1'b1;
        cyc("resume_pend", 32'h600, 1'b0, 1'b1, 1'b1);
        resume = 1'b0; pc_4 = 32'h604;
        cyc("run_after_pend", 32'h604, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset clears the counter before any clock edge.
        rst = 1'b1; m_cnt = '0;
        cyc("rst2", RST_PC, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Long stall saturates the counter; a redirect is parked on entry.
        pc_4 = 32'h700; md_busy = 1'b1; br_take = 1'b1; br_target = 32'h800;
        cyc("sat_entry", 32'h700, 1'b1, 1'b0, 1'b0);
        br_take = 1'b0;
        for (int i = 1; i < 20; i++) begin
            cyc("sat", 32'h700, 1'b1, 1'b0, 1'b0);
        end
        // Reset mid-stall discards the parked redirect.
        rst = 1'b1; m_cnt = '0;
        cyc("rst_mid_stall", RST_PC, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; md_busy = 1'b0; pc_4 = 32'h704;
        cyc("pend_discarded", 32'h704, 1'b0, 1'b0, 1'b0);

        // Reset mid-halt drops halted immediately.
        halt_req = 1'b1;
        cyc("halt_again", 32'h704, 1'b1, 1'b1, 1'b0);
        halt_req = 1'b0;
        cyc("halted_again", 32'h704, 1'b1, 1'b0, 1'b1);
        rst = 1'b1; m_cnt = '0;
        cyc("rst_mid_halt", RST_PC, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("run_after_rst", 32'h704, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
